// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage memory-access unit:
// addressing-mode codes, FSM state encoding and a constant clog2 helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    PTR_PLAIN   = 2'b00,
    PTR_POSTINC = 2'b01,
    PTR_PREDEC  = 2'b10,
    PTR_DISP    = 2'b11
  } ptr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge bus between the memory-access unit (master)
// and the memory I/O unit (slave).
interface mem_access_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_ptr_file.sv
// Pointer register file. The last pointer doubles as the stack pointer
// and has its own reset value. SFR-side writes take priority over the
// post-increment / pre-decrement update committed on a memory ack.
module mem_ptr_file
  import mem_access_pkg::*;
#(
  parameter int                NUM_PTRS  = 4,
  parameter int                ADDR_W    = 16,
  parameter int                PTR_SEL_W = 2,
  parameter logic [ADDR_W-1:0] SP_RESET  = '1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [PTR_SEL_W-1:0]       wr_sel,
  input  logic [ADDR_W-1:0]          wr_data,
  input  logic                       upd_en,
  input  logic [PTR_SEL_W-1:0]       upd_sel,
  input  logic [ADDR_W-1:0]          upd_data,
  output logic [NUM_PTRS*ADDR_W-1:0] ptr_out
);

  logic [ADDR_W-1:0] ptrs [NUM_PTRS];

  // Pointer storage: reset values, then SFR write over ack-cycle update
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PTRS; i++) begin
        ptrs[i] <= (i == NUM_PTRS - 1) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NUM_PTRS; i++) begin
        if (wr_en && (int'(wr_sel) == i)) begin
          ptrs[i] <= wr_data;
        end else if (upd_en && (int'(upd_sel) == i)) begin
          ptrs[i] <= upd_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PTRS; g++) begin : g_flat
    assign ptr_out[g*ADDR_W +: ADDR_W] = ptrs[g];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory-access unit: computes the effective address from a
// pointer and addressing mode, runs one request/ack transaction to the
// memory I/O unit while stalling the pipeline, extends load data and
// raises a sticky fault when the bus does not answer in time.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter int                NUM_PTRS  = 4,
  parameter int                TIMEOUT   = 255,
  parameter logic [ADDR_W-1:0] SP_RESET  = '1,
  localparam int               PTR_SEL_W = (clog2(NUM_PTRS) > 1) ? clog2(NUM_PTRS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic                       op_is_store,
  input  logic [PTR_SEL_W-1:0]       op_ptr_sel,
  input  logic [1:0]                 op_ptr_mode,
  input  logic [7:0]                 op_disp,
  input  logic                       op_signed,
  input  logic [DATA_W-1:0]          op_store_data,
  output logic                       stall,
  output logic                       ld_valid,
  output logic [2*DATA_W-1:0]        ld_data,
  input  logic                       ptr_wr_en,
  input  logic [PTR_SEL_W-1:0]       ptr_wr_sel,
  input  logic [ADDR_W-1:0]          ptr_wr_data,
  output logic [NUM_PTRS*ADDR_W-1:0] ptr_out,
  mem_access_if.master               mem,
  output logic                       fault,
  input  logic                       fault_clr
);

  localparam int WAIT_W = (clog2(TIMEOUT + 1) > 1) ? clog2(TIMEOUT + 1) : 1;

  function automatic logic [2*DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                      input logic              sgn);
    return sgn ? {{DATA_W{d[DATA_W-1]}}, d} : {{DATA_W{1'b0}}, d};
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  signed_q;
  ptr_mode_e             mode_q;
  logic [PTR_SEL_W-1:0]  sel_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [2*DATA_W-1:0]   ld_data_q;
  logic                  fault_q;

  logic                  accept;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  req;
  logic [ADDR_W-1:0]     ptr_cur;
  logic [ADDR_W-1:0]     eff_addr;
  logic signed [7:0]     disp_s;
  logic                  upd_en;
  logic [ADDR_W-1:0]     upd_data;

  // Selected pointer value for the op in the EX/MEM register
  always_comb begin
    ptr_cur = '0;
    for (int i = 0; i < NUM_PTRS; i++) begin
      if (int'(op_ptr_sel) == i) ptr_cur = ptr_out[i*ADDR_W +: ADDR_W];
    end
  end

  // Effective address by addressing mode, modulo 2^ADDR_W
  always_comb begin
    disp_s = signed'(op_disp);
    case (ptr_mode_e'(op_ptr_mode))
      PTR_PREDEC: eff_addr = ptr_cur - ADDR_W'(1);
      PTR_DISP:   eff_addr = ptr_cur + ADDR_W'(disp_s);
      default:    eff_addr = ptr_cur;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, handshake and stall decode
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    req         = 1'b0;
    ld_valid    = 1'b0;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        req   = 1'b1;
        if (mem.mem_ack) begin
          ack_hit = 1'b1;
          state_d = ST_DONE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        ld_valid = ~we_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Op capture, wait counter, load result and sticky fault
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      signed_q   <= 1'b0;
      mode_q     <= PTR_PLAIN;
      sel_q      <= '0;
      wait_cnt_q <= '0;
      ld_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= eff_addr;
        we_q       <= op_is_store;
        wdata_q    <= op_store_data;
        signed_q   <= op_signed;
        mode_q     <= ptr_mode_e'(op_ptr_mode);
        sel_q      <= op_ptr_sel;
        wait_cnt_q <= '0;
      end else if (state_q == ST_ACCESS) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (ack_hit && !we_q) begin
        ld_data_q <= extend_load(mem.mem_rdata, signed_q);
      end else if (timeout_hit) begin
        ld_data_q <= '0;
      end
      if (timeout_hit)    fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
    end
  end

  // Pointer writeback derives from the latched address, so SFR writes
  // made after the op was accepted do not alter its update value.
  assign upd_en   = ack_hit && ((mode_q == PTR_POSTINC) || (mode_q == PTR_PREDEC));
  assign upd_data = (mode_q == PTR_POSTINC) ? addr_q + ADDR_W'(1) : addr_q;

  mem_ptr_file #(
    .NUM_PTRS  (NUM_PTRS),
    .ADDR_W    (ADDR_W),
    .PTR_SEL_W (PTR_SEL_W),
    .SP_RESET  (SP_RESET)
  ) u_ptr_file (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (ptr_wr_en),
    .wr_sel   (ptr_wr_sel),
    .wr_data  (ptr_wr_data),
    .upd_en   (upd_en),
    .upd_sel  (sel_q),
    .upd_data (upd_data),
    .ptr_out  (ptr_out)
  );

  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ld_data       = ld_data_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops with a scoreboard of expected
// load results, popped whenever the unit presents ld_valid.
module tb_mem_access_unit;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 16;
  localparam int NUM_PTRS = 4;
  localparam int TIMEOUT  = 255;
  localparam logic [63:0] PTR_RST = 64'hFFFF_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_is_store = 1'b0;
  logic [1:0]  op_ptr_sel = '0;
  logic [1:0]  op_ptr_mode = '0;
  logic [7:0]  op_disp = '0;
  logic        op_signed = 1'b0;
  logic [7:0]  op_store_data = '0;
  logic        stall;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ptr_wr_en = 1'b0;
  logic [1:0]  ptr_wr_sel = '0;
  logic [15:0] ptr_wr_data = '0;
  logic [63:0] ptr_out;
  logic        fault;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  mem_access_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

  mem_access_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PTRS(NUM_PTRS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_is_store(op_is_store), .op_ptr_sel(op_ptr_sel),
    .op_ptr_mode(op_ptr_mode), .op_disp(op_disp), .op_signed(op_signed),
    .op_store_data(op_store_data),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .ptr_wr_en(ptr_wr_en), .ptr_wr_sel(ptr_wr_sel), .ptr_wr_data(ptr_wr_data),
    .ptr_out(ptr_out), .mem(mif), .fault(fault), .fault_clr(fault_clr)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every ld_valid cycle must match the next queued load
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (ld_valid) begin
        if (sb.size() == 0) check_val("ld_unexpected", 1, 0);
        else                check_val("ld_data", ld_data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_stall"},  stall, 0);
    check_val({pfx, "_req"},    mif.mem_req, 0);
    check_val({pfx, "_we"},     mif.mem_we, 0);
    check_val({pfx, "_addr"},   mif.mem_addr, 0);
    check_val({pfx, "_wdata"},  mif.mem_wdata, 0);
    check_val({pfx, "_ldv"},    ld_valid, 0);
    check_val({pfx, "_lddata"}, ld_data, 0);
    check_val({pfx, "_fault"},  fault, 0);
    check_val({pfx, "_ptrs"},   ptr_out, PTR_RST);
  endtask

  task automatic wr_ptr(input logic [1:0] sel, input logic [15:0] val);
    @(negedge clock);
    ptr_wr_en = 1'b1; ptr_wr_sel = sel; ptr_wr_data = val;
    @(negedge clock);
    ptr_wr_en = 1'b0;
  endtask

  task automatic pulse_fault_clr();
    @(negedge clock);
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    #1;
    check_val("fault_cleared", fault, 0);
  endtask

  // One complete op; waits < 0 means the memory never acknowledges.
  // coll drives an SFR write of 0x2222 to the same pointer in the ack cycle.
  task automatic run_op(input logic st, input logic [1:0] sel, input logic [1:0] mode,
                        input logic [7:0] disp, input logic sgn, input logic [7:0] wd,
                        input logic [7:0] rd, input int waits, input logic coll,
                        input logic clr_during, input logic [15:0] exp_addr,
                        input int exp_stall, input logic [15:0] exp_ld);
    int stall_cnt;
    bit done;
    @(negedge clock);
    op_valid = 1'b1; op_is_store = st; op_ptr_sel = sel; op_ptr_mode = mode;
    op_disp = disp; op_signed = sgn; op_store_data = wd; fault_clr = clr_during;
    if (!st) sb.push_back(exp_ld);
    #1;
    check_val("stall_t0", stall, 1);
    stall_cnt = stall ? 1 : 0;
    done = 0;
    for (int k = 1; k <= TIMEOUT + 4 && !done; k++) begin
      @(negedge clock);
      op_valid = 1'b0;
      mif.mem_ack = (k - 1 == waits);
      mif.mem_rdata = rd;
      if (coll && (k - 1 == waits)) begin
        ptr_wr_en = 1'b1; ptr_wr_sel = sel; ptr_wr_data = 16'h2222;
      end else begin
        ptr_wr_en = 1'b0;
      end
      #1;
      if (k == 1) begin
        check_val("req_access", mif.mem_req, 1);
        check_val("mem_addr", mif.mem_addr, exp_addr);
        check_val("mem_we", mif.mem_we, st);
        if (st) check_val("mem_wdata", mif.mem_wdata, wd);
      end
      if (stall) stall_cnt++;
      else       done = 1;
    end
    if (!done) check_val("op_bound", 0, 1);
    mif.mem_ack = 1'b0;
    ptr_wr_en = 1'b0;
    check_val("req_drop", mif.mem_req, 0);
    check_val("stall_cycles", stall_cnt, exp_stall);
    if (clr_during) check_val("fault_wins_clr", fault, 1);
    fault_clr = 1'b0;
  endtask

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_state("rst");

    // Signed load, post-increment on ptr0, ack on first access cycle
    wr_ptr(2'd0, 16'h1000);
    run_op(1'b0, 2'd0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h80, 0, 1'b0, 1'b0, 16'h1000, 2, 16'hFF80);
    check_val("ptr0_postinc", ptr_out[15:0], 16'h1001);

    // Store, pre-decrement on the stack pointer, three wait cycles
    run_op(1'b1, 2'd3, 2'b10, 8'h00, 1'b0, 8'hA5, 8'h00, 3, 1'b0, 1'b0, 16'hFFFE, 5, 16'h0);
    check_val("sp_predec", ptr_out[63:48], 16'hFFFE);

    // Displacement with wraparound, unsigned load
    wr_ptr(2'd1, 16'h0005);
    run_op(1'b0, 2'd1, 2'b11, 8'hF0, 1'b0, 8'h00, 8'h80, 0, 1'b0, 1'b0, 16'hFFF5, 2, 16'h0080);
    check_val("ptr1_disp_keep", ptr_out[31:16], 16'h0005);

    // Post-increment wraps 0xFFFF -> 0x0000
    wr_ptr(2'd2, 16'hFFFF);
    run_op(1'b0, 2'd2, 2'b01, 8'h00, 1'b1, 8'h00, 8'h7F, 0, 1'b0, 1'b0, 16'hFFFF, 2, 16'h007F);
    check_val("ptr2_wrap", ptr_out[47:32], 16'h0000);

    // Bus timeout on a load: fault, zero result, no pointer update
    run_op(1'b0, 2'd0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h55, -1, 1'b0, 1'b0, 16'h1001, TIMEOUT + 1, 16'h0000);
    check_val("fault_set", fault, 1);
    check_val("ptr0_timeout_keep", ptr_out[15:0], 16'h1001);
    check_val("lddata_timeout", ld_data, 0);
    pulse_fault_clr();

    // Timeout while fault_clr is held: the timeout wins
    run_op(1'b1, 2'd1, 2'b00, 8'h00, 1'b0, 8'h11, 8'h00, -1, 1'b0, 1'b1, 16'h0005, TIMEOUT + 1, 16'h0);
    pulse_fault_clr();

    // Normal store after fault recovery, one wait cycle
    run_op(1'b1, 2'd1, 2'b00, 8'h00, 1'b0, 8'h3C, 8'h00, 1, 1'b0, 1'b0, 16'h0005, 3, 16'h0);
    check_val("fault_after_ok", fault, 0);
    check_val("ptr1_plain_keep", ptr_out[31:16], 16'h0005);

    // SFR write collides with ack-cycle post-increment on ptr0
    run_op(1'b0, 2'd0, 2'b01, 8'h00, 1'b0, 8'h00, 8'h01, 0, 1'b1, 1'b0, 16'h1001, 2, 16'h0001);
    check_val("ptr0_collision", ptr_out[15:0], 16'h2222);

    // Reset in the second access cycle, then a stray ack while idle
    @(negedge clock);
    op_valid = 1'b1; op_is_store = 1'b0; op_ptr_sel = 2'd0; op_ptr_mode = 2'b01;
    @(negedge clock);
    op_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("req_before_reset", mif.mem_req, 1);
    @(negedge clock);
    reset = 1'b0;
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 8'hC3;
    #1;
    check_reset_state("midrst");
    @(negedge clock);
    mif.mem_ack = 1'b0;
    #1;
    check_reset_state("lateack");

    repeat (3) @(negedge clock);
    check_val("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
